// File: rtl/prng_arbiter.sv
// -----------------------------------------------------------------------------
// prng_arbiter
//
// Round-robin arbiter and reseed sequencer sitting in front of a single
// xoshiro128++ core. One draw per cycle is shared among NUM_REQ requesters;
// a 128-bit reseed is written into the core's four state words, optionally
// followed by WARMUP discarded draws.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WARMUP   draws discarded after each reseed (0..255)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req               level request per requester
//   rnd_valid         registered one-hot delivery strobe
//   rnd_data          delivered word (pass-through of prng_rnd)
//   seed_start, seed  reseed command and 128-bit seed
//   busy              high while loading the seed or warming up
//   prng_next         draw strobe to the core
//   prng_rnd          core output register
//   prng_write*       state-word write strobe / index / data to the core
//   draw_count        total draws issued (0 unless stats are enabled)
//
// Build option: define PRNG_ARB_STATS_EN to generate the draw counter.
// -----------------------------------------------------------------------------
module prng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rnd_valid,
  output logic [31:0]        rnd_data,
  input  logic               seed_start,
  input  logic [127:0]       seed,
  output logic               busy,
  output logic               prng_next,
  input  logic [31:0]        prng_rnd,
  output logic               prng_write,
  output logic [1:0]         prng_write_addr,
  output logic [31:0]        prng_write_data,
  output logic [31:0]        draw_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_WARMUP
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [127:0]       seed_q, seed_d;
  logic [1:0]         word_q, word_d;
  logic [7:0]         warm_q, warm_d;
  logic [NUM_REQ-1:0] valid_q, valid_d;

  logic               grant_found;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand_idx;

  // Cyclic search starting just after the last granted index, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand_idx    = ptr_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = PTR_W'((int'(ptr_q) + off) % NUM_REQ);
      if (!grant_found && req[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d         = state_q;
    ptr_d           = ptr_q;
    seed_d          = seed_q;
    word_d          = word_q;
    warm_d          = warm_q;
    valid_d         = '0;
    prng_next       = 1'b0;
    prng_write      = 1'b0;
    prng_write_addr = 2'd0;
    prng_write_data = 32'd0;

    unique case (state_q)
      ST_RUN: begin
        if (seed_start) begin
          // Reseed wins over any pending request in the same cycle.
          state_d = ST_LOAD;
          seed_d  = seed;
          word_d  = 2'd0;
          warm_d  = 8'd0;
        end else if (grant_found && !rst) begin
          // Held off during reset so outputs stay at their reset values.
          prng_next = 1'b1;
          ptr_d     = grant_idx;
          valid_d   = NUM_REQ'(1) << grant_idx;
        end
      end

      ST_LOAD: begin
        // The core gives write priority over next, so no draw is issued here.
        prng_write      = 1'b1;
        prng_write_addr = word_q;
        prng_write_data = seed_q[{word_q, 5'd0} +: 32];
        if (seed_start) begin
          seed_d = seed;
          word_d = 2'd0;
          warm_d = 8'd0;
        end else if (word_q == 2'd3) begin
          state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
          warm_d  = 8'd0;
        end else begin
          word_d = word_q + 2'd1;
        end
      end

      ST_WARMUP: begin
        prng_next = 1'b1;
        if (seed_start) begin
          state_d = ST_LOAD;
          seed_d  = seed;
          word_d  = 2'd0;
          warm_d  = 8'd0;
        end else if (warm_q == 8'(WARMUP - 1)) begin
          state_d = ST_RUN;
        end else begin
          warm_d = warm_q + 8'd1;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      word_q  <= 2'd0;
      warm_q  <= 8'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      warm_q  <= warm_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the seed holding register is pure data, only read in LOAD after it
  // has been loaded, so it needs no reset.
  always_ff @(posedge clk) begin
    seed_q <= seed_d;
  end

  assign rnd_valid = valid_q;
  assign rnd_data  = prng_rnd;
  assign busy      = (state_q != ST_RUN);

`ifdef PRNG_ARB_STATS_EN
  logic [31:0] draw_count_q, draw_count_d;

  // Counts every draw, warm-up included; wraps naturally at 2^32.
  always_comb begin
    draw_count_d = draw_count_q + 32'(prng_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      draw_count_q <= 32'd0;
    end else begin
      draw_count_q <= draw_count_d;
    end
  end

  assign draw_count = draw_count_q;
`else
  assign draw_count = 32'd0;
`endif

endmodule

// File: doc/prng_arbiter.md
# prng_arbiter

Round-robin arbiter and seeding sequencer in front of the single xoshiro128++ PRNG core on the peripheral bus. It shares one draw per cycle among `NUM_REQ` requesters and sequences 128-bit reseeds into the core's four state words. It also runs an optional warm-up that discards outputs after reseeding. It owns the core's `next` and `write*` inputs exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `WARMUP`, 8: outputs discarded after each reseed, legal range 0..255.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset. Top level drives the core's `rst_n` as `~rst`.
- `req` in NUM_REQ: level request, one bit per requester.
- `rnd_valid` out NUM_REQ: one-hot pulse marking delivery to requester i.
- `rnd_data` out 32: delivered word; direct pass-through of `prng_rnd`.
- `seed_start` in 1: single-cycle reseed command.
- `seed` in 128: seed value, sampled when `seed_start`=1.
- `busy` out 1: high while in LOAD or WARMUP.
- `prng_next` out 1: draw strobe to the core.
- `prng_rnd` in 32: core output register.
- `prng_write` out 1: state-write strobe to the core.
- `prng_write_addr` out 2: state word index.
- `prng_write_data` out 32: state word.
- `draw_count` out 32: total draws issued (see Configuration).

## Operation
- FSM states and transitions:
  - RUN → LOAD on `seed_start`.
  - LOAD → WARMUP after 4 write cycles, or LOAD → RUN if `WARMUP`=0.
  - WARMUP → RUN after `WARMUP` draws.
- Reset values:
  - State = RUN; the core's reset seed is used as-is.
  - Round-robin pointer = NUM_REQ-1, so index 0 has priority first.
  - `rnd_valid`=0, `busy`=0, `prng_next`=0, `prng_write`=0, `prng_write_addr`=0, `prng_write_data`=0, `draw_count`=0.
- RUN behaviour:
  - If any `req` bit is set and `seed_start`=0, grant the first set bit after the pointer, searching cyclically.
  - Assert `prng_next` and update the pointer to the granted index.
  - Register the grant one-hot for delivery.
  - A requester holding `req` high receives one word each time it is granted.
  - To take exactly one word, the requester drops `req` in the cycle its `rnd_valid` is high.
- LOAD behaviour:
  - `seed` is latched on `seed_start`.
  - Over 4 consecutive cycles, assert `prng_write` with addr 0,1,2,3 and data `seed[31:0]`, `[63:32]`, `[95:64]`, `[127:96]`.
  - `prng_next`=0 throughout, because write has priority in the core.
- WARMUP behaviour:
  - Assert `prng_next` for `WARMUP` consecutive cycles.
  - No `rnd_valid` is generated.
- Grants are blocked while `busy`=1.
- `prng_write` and `prng_next` are never high in the same cycle.
- `seed_start` in RUN together with `req`: reseed wins and no grant is issued that cycle.
- `seed_start` during LOAD or WARMUP: re-latch `seed` and restart LOAD at word 0; the warm-up count is reset.
- A grant issued in the cycle before LOAD starts is still delivered, because writes do not alter `prng_rnd`.
- `rst` mid-LOAD or mid-WARMUP: return to RUN immediately. The core is reset to its default seed in the same edge.

## Timing
- Grant latency:
  - `prng_next` is combinational from `req`, state and pointer in cycle N.
  - `rnd_valid[i]` is registered and high in cycle N+1.
  - `rnd_data` is valid in N+1 only.
- Throughput: one word per cycle, back-to-back across requesters.
- Reseed cost:
  - `busy` rises in the cycle after `seed_start`.
  - `busy` lasts 4+`WARMUP` cycles.
  - The first grant is possible in the cycle after `busy` falls.

## Configuration
- `PRNG_ARB_STATS_EN` defined:
  - `draw_count` increments on every `prng_next`, including warm-up draws.
  - Wraps modulo 2^32; cleared only by `rst`.
- `PRNG_ARB_STATS_EN` undefined: `draw_count` is tied to 0 and no counter logic is generated.

## Test plan
- Reseed ordering:
  - Stimulus: `WARMUP`=0, `seed`=128'h00000004_00000003_00000002_00000001, `seed_start` pulsed.
  - Required: writes addr 0..3 with data 1,2,3,4 on consecutive cycles; `busy` high for exactly 4 cycles.
- Reseed output values: after the same reseed, hold `req`=4'b0001.
  - First delivery: `rnd_valid`=4'b0001, `rnd_data`=32'h00000281.
  - Next delivery: `rnd_data`=32'h00180387.
- Round-robin fairness: `req`=4'b1111 held for 8 cycles after reset → `rnd_valid` sequence 0,1,2,3,0,1,2,3, one per cycle; `draw_count`=8 with the macro defined.
- Skip of idle requesters: `req`=4'b1010 held → grants alternate 1,3,1,3, with no pulses on bits 0 or 2.
- Warm-up:
  - `WARMUP`=3 reseed with `req`=4'b0001 held.
  - Required: no `rnd_valid` for 7 cycles; `prng_next` high in exactly the final 3 of them; first delivery follows.
- Restart and abort:
  - `seed_start` again at LOAD word 2 → LOAD restarts at addr 0 with the new seed.
  - `rst` asserted mid-WARMUP → state RUN, `busy`=0, all outputs at reset values next cycle.
